lenet_argmax_fp16: RTL and testbench

// - Classifier stage directly downstream of the F7 fully-connected layer: consumes the flat
//   bus of NUM_CLASS FP16 logits and reports the index and value of the largest logit.
// - Sequential scan, one logit compared per clock; start/busy/done handshake so the top

---
 rtl/lenet_pkg.sv | 35 +++
 rtl/fp16_gt.sv | 47 ++++
 rtl/lenet_argmax_fp16.sv | 152 +++++++++++++++
 tb/tb_lenet_argmax_fp16.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet post-processing blocks.
// - fp16_t: IEEE half-precision value split into sign / exponent / mantissa.
// - FP16_POS_ZERO, FP16_NEG_INF: frequently used constant encodings.
// - argmax_state_e: state encoding of the argmax scanner.
// - is_nan(), is_zero(): classification helpers.
package lenet_pkg;

  localparam int FP16_W = 16;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] mant;
  } fp16_t;

  localparam fp16_t FP16_POS_ZERO = '{sign: 1'b0, exp: 5'h00, mant: 10'h000};
  localparam fp16_t FP16_NEG_INF  = '{sign: 1'b1, exp: 5'h1f, mant: 10'h000};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } argmax_state_e;

  // exp all-ones with a non-zero mantissa; both quiet and signalling NaNs match.
  function automatic logic is_nan(input fp16_t v);
    return (v.exp == 5'h1f) && (v.mant != 10'h000);
  endfunction

  // +0 and -0 share the all-zero magnitude.
  function automatic logic is_zero(input fp16_t v);
    return (v.exp == 5'h00) && (v.mant == 10'h000);
  endfunction

endpackage

// File: rtl/fp16_gt.sv
// Combinational strict greater-than of two FP16 values (a > b).
// Ports:
//   a, b    : FP16 operands (raw bits)
//   a_gt_b  : 1 when a is strictly greater than b
// Ordering rules:
//   - a NaN never wins; any non-NaN a beats a NaN b (lets a NaN seed value
//     be displaced by the first real number).
//   - +0 and -0 compare equal.
//   - Otherwise a sign-magnitude compare: exponent/mantissa concatenation is
//     monotonic in magnitude for every class including subnormals and Inf.
module fp16_gt
  import lenet_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        a_gt_b
);

  fp16_t      fa;
  fp16_t      fb;
  logic [14:0] mag_a;
  logic [14:0] mag_b;

  always_comb begin
    fa     = fp16_t'(a);
    fb     = fp16_t'(b);
    mag_a  = {fa.exp, fa.mant};
    mag_b  = {fb.exp, fb.mant};
    a_gt_b = 1'b0;
    if (is_nan(fa)) begin
      a_gt_b = 1'b0;
    end else if (is_nan(fb)) begin
      a_gt_b = 1'b1;
    end else if (is_zero(fa) && is_zero(fb)) begin
      a_gt_b = 1'b0;
    end else if (fa.sign != fb.sign) begin
      // Different signs and not both zero: the positive one is larger.
      a_gt_b = fb.sign;
    end else if (!fa.sign) begin
      a_gt_b = (mag_a > mag_b);
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      a_gt_b = (mag_a < mag_b);
    end
  end

endmodule

// File: rtl/lenet_argmax_fp16.sv
// Argmax over the F7 logit bus: one FP16 logit compared per clock.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low; clears all state
//   start      : begin a classification (only honoured in IDLE)
//   logits     : NUM_CLASS FP16 values, logit i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy       : high while in SCAN or DONE
//   done       : one-cycle pulse when class_idx/max_val/all_nan are updated
//   class_idx  : index of the largest logit (lowest index on ties)
//   max_val    : bits of the largest logit
//   all_nan    : every logit was NaN (class_idx=0, max_val=logit0)
//   state_dbg  : current FSM state, for observation only
// Handshake: start is a level request sampled on the clock edge while IDLE;
// the bus is captured on that same edge. Results are stable from the done
// pulse until the next done pulse. start high in IDLE re-arms immediately,
// giving one run every NUM_CLASS+1 cycles.
// Timeline: accept edge k loads logit0 as best; edges k+1..k+NUM_CLASS-1
// compare one logit each; edge k+NUM_CLASS (DONE) registers the outputs.
module lenet_argmax_fp16
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CLASS  = 10,
  parameter int IDX_W      = $clog2(NUM_CLASS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_CLASS*DATA_WIDTH-1:0] logits,
  output logic                            busy,
  output logic                            done,
  output logic [IDX_W-1:0]                class_idx,
  output logic [DATA_WIDTH-1:0]           max_val,
  output logic                            all_nan,
  output logic [1:0]                      state_dbg
);

  // Counter is one bit wider than the index so NUM_CLASS = 2**IDX_W fits.
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(NUM_CLASS - 1);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

  argmax_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] snap_q [NUM_CLASS];
  logic [DATA_WIDTH-1:0] snap_d [NUM_CLASS];
  logic [IDX_W:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] best_q, best_d;
  logic [IDX_W-1:0]      best_idx_q, best_idx_d;
  logic                  done_q, done_d;
  logic [IDX_W-1:0]      class_idx_q, class_idx_d;
  logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
  logic                  all_nan_q, all_nan_d;

  logic [DATA_WIDTH-1:0] cand;
  logic                  cand_gt;

  assign cand = snap_q[cnt_q[IDX_W-1:0]];

  fp16_gt u_gt (
    .a      (cand),
    .b      (best_q),
    .a_gt_b (cand_gt)
  );

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    cnt_d       = cnt_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    done_d      = 1'b0;
    class_idx_d = class_idx_q;
    max_val_d   = max_val_q;
    all_nan_d   = all_nan_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_CLASS; i++) begin
            snap_d[i] = logits[i*DATA_WIDTH +: DATA_WIDTH];
          end
          // logit0 seeds best even if it is NaN; fp16_gt lets any
          // non-NaN candidate displace it later.
          best_d     = logits[DATA_WIDTH-1:0];
          best_idx_d = '0;
          cnt_d      = CNT_ONE;
          state_d    = ST_SCAN;
        end
      end

      ST_SCAN: begin
        // Strictly greater only: equal values keep the earlier index.
        if (cand_gt) begin
          best_d     = cand;
          best_idx_d = cnt_q[IDX_W-1:0];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        class_idx_d = best_idx_q;
        max_val_d   = best_q;
        // best stays NaN only if no non-NaN logit was ever seen.
        all_nan_d   = is_nan(fp16_t'(best_q));
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < NUM_CLASS; i++) begin
        snap_q[i] <= '0;
      end
      cnt_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      done_q      <= 1'b0;
      class_idx_q <= '0;
      max_val_q   <= DATA_WIDTH'(FP16_POS_ZERO);
      all_nan_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      done_q      <= done_d;
      class_idx_q <= class_idx_d;
      max_val_q   <= max_val_d;
      all_nan_q   <= all_nan_d;
    end
  end

  assign busy      = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign done      = done_q;
  assign class_idx = class_idx_q;
  assign max_val   = max_val_q;
  assign all_nan   = all_nan_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lenet_argmax_fp16.sv
// Directed bench for lenet_argmax_fp16 with an expected-result queue and an
// independent real-valued reference model of FP16 ordering.
module tb_lenet_argmax_fp16;

  localparam int NC = 10;
  localparam int DW = 16;
  localparam int IW = $clog2(NC);
  localparam int W  = 1 + IW + DW;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [NC*DW-1:0]   logits = '0;
  logic               busy;
  logic               done;
  logic [IW-1:0]      class_idx;
  logic [DW-1:0]      max_val;
  logic               all_nan;
  logic [1:0]         state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  lenet_argmax_fp16 #(.DATA_WIDTH(DW), .NUM_CLASS(NC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .logits    (logits),
    .busy      (busy),
    .done      (done),
    .class_idx (class_idx),
    .max_val   (max_val),
    .all_nan   (all_nan),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real fp_val(input logic [15:0] x);
    real m;
    int  e;
    e = int'(x[14:10]);
    if (e == 31)     m = 1.0e30;
    else if (e == 0) m = real'(x[9:0]) * (2.0 ** (-24));
    else             m = real'(1024 + int'(x[9:0])) * (2.0 ** (e - 25));
    return x[15] ? -m : m;
  endfunction

  function automatic logic [W-1:0] model(input logic [NC*DW-1:0] lg);
    int         bi;
    real        bv;
    real        v;
    logic [15:0] x;
    bi = -1;
    bv = 0.0;
    for (int i = 0; i < NC; i++) begin
      x = lg[i*DW +: DW];
      if (x[14:10] == 5'h1f && x[9:0] != 10'h0) continue;
      v = fp_val(x);
      if (bi < 0 || v > bv) begin
        bi = i;
        bv = v;
      end
    end
    if (bi < 0) return {1'b1, IW'(0), lg[DW-1:0]};
    return {1'b0, IW'(bi), lg[bi*DW +: DW]};
  endfunction

  // ---------------- drivers ----------------
  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < NC; i++) logits[i*DW +: DW] = v;
  endtask

  task automatic set_lg(input int i, input logic [15:0] v);
    logits[i*DW +: DW] = v;
  endtask

  task automatic push_exp(input logic nan, input int idx, input logic [15:0] val);
    exp_q.push_back({nan, IW'(idx), val});
  endtask

  task automatic compare_result(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_idx"}, 32'(class_idx), 32'(e[DW +: IW]));
      check({tag, "_val"}, 32'(max_val), 32'(e[DW-1:0]));
      check({tag, "_nan"}, 32'(all_nan), 32'(e[W-1]));
    end
  endtask

  // One run: start pulse, optional extra start pulses (pa/pb cycles after
  // acceptance) and an optional bus change (chg cycles after acceptance).
  task automatic run(input string tag, input int pa = -1, input int pb = -1,
                     input int chg = -1, input logic [NC*DW-1:0] new_lg = '0);
    int lat;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    forever begin
      @(negedge clk);
      lat++;
      if (done || lat >= 40) break;
      start = (lat == pa) || (lat == pb);
      if (lat == chg) logits = new_lg;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(NC));
    check({tag, "_done"}, 32'(done), 32'd1);
    compare_result(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] pool [14] = '{16'h3C00, 16'hBC00, 16'h0000, 16'h8000, 16'h7C00,
                             16'hFC00, 16'h0001, 16'h8001, 16'h7E00, 16'h4500,
                             16'hC500, 16'h3555, 16'h7BFF, 16'hFBFF};

  initial begin : main
    logic [NC*DW-1:0] saved;
    int               gap;
    int               pulses;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(class_idx), 32'd0);
    check("rst_val", 32'(max_val), 32'd0);
    check("rst_nan", 32'(all_nan), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b1;

    // single peak
    set_all(16'h3C00); set_lg(7, 16'h4500);
    push_exp(1'b0, 7, 16'h4500);
    run("peak");

    // tie keeps lower index
    set_all(16'h3C00); set_lg(2, 16'h4200); set_lg(6, 16'h4200);
    push_exp(1'b0, 2, 16'h4200);
    run("tie");

    // -0 and +0 equal: lower index wins
    set_all(16'hBC00); set_lg(3, 16'h8000); set_lg(5, 16'h0000);
    push_exp(1'b0, 3, 16'h8000);
    run("zero_tie");

    // all negative, least negative at idx9, with -Inf present
    for (int i = 0; i < NC; i++) set_lg(i, 16'hC900 - 16'(i * 16'h0100));
    set_lg(4, 16'hFC00);
    push_exp(1'b0, 9, 16'hC000);
    run("negatives");

    // subnormal beats zero
    set_all(16'h0000); set_lg(2, 16'h8001); set_lg(6, 16'h0001);
    push_exp(1'b0, 6, 16'h0001);
    run("subnormal");

    // +Inf beats largest finite
    set_all(16'h3C00); set_lg(1, 16'h7BFF); set_lg(8, 16'h7C00);
    push_exp(1'b0, 8, 16'h7C00);
    run("pos_inf");

    // NaN in logit0 displaced
    set_all(16'h3C00); set_lg(0, 16'h7E00); set_lg(4, 16'h4000);
    push_exp(1'b0, 4, 16'h4000);
    run("nan_first");

    // all NaN
    set_all(16'h7E01);
    push_exp(1'b1, 0, 16'h7E01);
    run("all_nan");

    // start pulses mid-run ignored; bus change mid-run ignored
    set_all(16'h3C00); set_lg(7, 16'h4500);
    saved = logits;
    saved[2*DW +: DW] = 16'h4800;
    push_exp(1'b0, 7, 16'h4500);
    run("handshake", 3, 9, 4, saved);

    // random mixes checked against the reference model
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NC; i++) set_lg(i, pool[$urandom_range(0, 13)]);
      exp_q.push_back(model(logits));
      run($sformatf("rand%0d", r));
    end

    // start held high: done every NC+1 cycles
    set_all(16'hBC00); set_lg(5, 16'h3C00);
    for (int i = 0; i < 3; i++) push_exp(1'b0, 5, 16'h3C00);
    @(negedge clk);
    start = 1'b1;
    for (int p = 0; p < 3; p++) begin
      gap = 0;
      forever begin
        @(negedge clk);
        gap++;
        if (done || gap >= 40) break;
      end
      if (p == 2) start = 1'b0;
      check($sformatf("held_gap%0d", p), 32'(gap), 32'(NC + 1));
      compare_result($sformatf("held%0d", p));
    end
    @(negedge clk);
    check("held_stop", 32'(busy), 32'd0);

    // reset mid-scan: no done, outputs back to reset values
    set_all(16'h3C00); set_lg(8, 16'h4400);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_idx", 32'(class_idx), 32'd0);
    check("arst_val", 32'(max_val), 32'd0);
    check("arst_nan", 32'(all_nan), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("arst_no_done", 32'(pulses), 32'd0);

    // normal run after reset
    push_exp(1'b0, 8, 16'h4400);
    run("post_reset");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
